procesando_transaccion: RTL

PROCESANDO_TRANSACCION -- requirements
Module: procesando_transaccion

---
 rtl/procesando_transaccion.sv | 123 ++++++++++++
 1 files changed

// File: rtl/procesando_transaccion.sv
// procesando_transaccion: ATM transaction engine (amount capture, deposit/withdrawal evaluation, result pulses)
module procesando_transaccion #(
    parameter int BAL_W       = 32,
    parameter int MAX_DIGITOS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic             tipo_trans,
    input  logic [BAL_W-1:0] balance_inicial,
    input  logic             digito_stb,
    input  logic [3:0]       digito,
    output logic [BAL_W-1:0] balance,
    output logic             balance_actualizado,
    output logic             entregar_dinero,
    output logic             fondos_insuficientes,
    output logic             fin_trans,
    output logic             ocupado
);
    localparam int CW = $clog2(MAX_DIGITOS + 1);

    typedef enum logic [1:0] {IDLE, CAPTURA, EVALUA, RESULTADO} estado_t;

    estado_t          r_state, w_state_nx;
    logic             r_tipo, w_tipo_nx;
    logic [BAL_W-1:0] r_balance, w_balance_nx;
    logic [BAL_W-1:0] r_monto, w_monto_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_act, w_act_nx;
    logic             r_entregar, w_entregar_nx;
    logic             r_fondos, w_fondos_nx;
    logic             r_fin, r_ocupado;
    logic [BAL_W:0]   w_suma;
    logic [BAL_W-1:0] w_mac;

    assign w_suma = {1'b0, r_balance} + {1'b0, r_monto};
    assign w_mac  = (r_monto << 3) + (r_monto << 1) + BAL_W'(digito);

    // State, datapath and registered outputs; every pulse is the registered image of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tipo     <= 1'b0;
            r_balance  <= '0;
            r_monto    <= '0;
            r_cnt      <= '0;
            r_act      <= 1'b0;
            r_entregar <= 1'b0;
            r_fondos   <= 1'b0;
            r_fin      <= 1'b0;
            r_ocupado  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tipo     <= w_tipo_nx;
            r_balance  <= w_balance_nx;
            r_monto    <= w_monto_nx;
            r_cnt      <= w_cnt_nx;
            r_act      <= w_act_nx;
            r_entregar <= w_entregar_nx;
            r_fondos   <= w_fondos_nx;
            r_fin      <= (w_state_nx == RESULTADO);
            r_ocupado  <= (w_state_nx != IDLE);
        end
    end

    // Next state, amount capture and the EVALUA decision
    always_comb begin
        w_state_nx    = r_state;
        w_tipo_nx     = r_tipo;
        w_balance_nx  = r_balance;
        w_monto_nx    = r_monto;
        w_cnt_nx      = r_cnt;
        w_act_nx      = 1'b0;
        w_entregar_nx = 1'b0;
        w_fondos_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (inicio) begin
                    w_state_nx   = CAPTURA;
                    w_tipo_nx    = tipo_trans;
                    w_balance_nx = balance_inicial;
                    w_monto_nx   = '0;
                    w_cnt_nx     = '0;
                end
            end
            CAPTURA: begin
                if (digito_stb) begin
                    if (digito <= 4'd9) begin
                        if (r_cnt < CW'(MAX_DIGITOS)) begin
                            w_monto_nx = w_mac;
                            w_cnt_nx   = r_cnt + CW'(1);
                        end
                    end else if (digito == 4'hB) begin
                        w_state_nx = (r_cnt != '0) ? EVALUA : CAPTURA;
                    end else if (digito == 4'hC) begin
                        w_state_nx = RESULTADO;
                    end
                end
            end
            EVALUA: begin
                w_state_nx = RESULTADO;
                if (!r_tipo) begin
                    w_balance_nx = w_suma[BAL_W] ? '1 : w_suma[BAL_W-1:0];
                    w_act_nx     = 1'b1;
                end else if (r_monto <= r_balance) begin
                    w_balance_nx  = r_balance - r_monto;
                    w_act_nx      = 1'b1;
                    w_entregar_nx = 1'b1;
                end else begin
                    w_fondos_nx = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign balance              = r_balance;
    assign balance_actualizado  = r_act;
    assign entregar_dinero      = r_entregar;
    assign fondos_insuficientes = r_fondos;
    assign fin_trans            = r_fin;
    assign ocupado              = r_ocupado;
endmodule
